// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs a big-endian word stream into FIPS 180-4 padded
// 512-bit blocks, adding the 0x80 marker, zero fill and the 64-bit bit length.
module sha256_padder (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         in_last,
    input  logic [1:0]   in_nbytes,
    output logic         block_valid,
    input  logic         block_ready,
    output logic [511:0] block_data,
    output logic         block_first,
    output logic         block_last
);

    localparam logic [2:0] FILL = 3'd0;
    localparam logic [2:0] PAD  = 3'd1;
    localparam logic [2:0] ZERO = 3'd2;
    localparam logic [2:0] LEN  = 3'd3;
    localparam logic [2:0] EMIT = 3'd4;

    logic [2:0]  state;
    logic [2:0]  ret;
    logic [3:0]  widx;
    logic [63:0] bitlen;
    logic        first;
    logic [31:0] wbuf [16];
    logic [31:0] last_word;
    logic [2:0]  word_bytes;

    // Final word keeps only its valid lanes and carries the marker in the next lane.
    always_comb begin
        case (in_nbytes)
            2'd1:    last_word = {in_data[31:24], 8'h80, 16'h0000};
            2'd2:    last_word = {in_data[31:16], 8'h80, 8'h00};
            2'd3:    last_word = {in_data[31:8], 8'h80};
            default: last_word = in_data;
        endcase
        word_bytes = (in_last && in_nbytes != 2'd0) ? {1'b0, in_nbytes} : 3'd4;
    end

    always_comb begin
        block_data = '0;
        for (int k = 0; k < 16; k++) begin
            block_data[511 - 32*k -: 32] = wbuf[k];
        end
    end

    assign in_ready    = (state == FILL);
    assign block_first = first;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FILL;
            ret         <= FILL;
            widx        <= 4'd0;
            bitlen      <= 64'd0;
            first       <= 1'b1;
            block_valid <= 1'b0;
            block_last  <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (in_valid) begin
                        wbuf[widx] <= in_last ? last_word : in_data;
                        bitlen     <= bitlen + {58'd0, word_bytes, 3'b000};
                        widx       <= widx + 4'd1;
                        if (!in_last) begin
                            if (widx == 4'd15) begin
                                state       <= EMIT;
                                ret         <= FILL;
                                block_valid <= 1'b1;
                            end
                        end else if (widx == 4'd15) begin
                            state       <= EMIT;
                            ret         <= (in_nbytes == 2'd0) ? PAD : ZERO;
                            block_valid <= 1'b1;
                        end else begin
                            state <= (in_nbytes == 2'd0) ? PAD : ZERO;
                        end
                    end
                end
                PAD: begin
                    wbuf[widx] <= 32'h8000_0000;
                    widx       <= widx + 4'd1;
                    if (widx == 4'd15) begin
                        state       <= EMIT;
                        ret         <= ZERO;
                        block_valid <= 1'b1;
                    end else begin
                        state <= ZERO;
                    end
                end
                ZERO: begin
                    // Writing word 13 hands straight over to LEN so the length lands without an idle cycle.
                    if (widx == 4'd14) begin
                        state <= LEN;
                    end else begin
                        wbuf[widx] <= 32'h0000_0000;
                        widx       <= widx + 4'd1;
                        if (widx == 4'd13) begin
                            state <= LEN;
                        end else if (widx == 4'd15) begin
                            state       <= EMIT;
                            ret         <= ZERO;
                            block_valid <= 1'b1;
                        end
                    end
                end
                LEN: begin
                    wbuf[14]    <= bitlen[63:32];
                    wbuf[15]    <= bitlen[31:0];
                    state       <= EMIT;
                    block_valid <= 1'b1;
                    block_last  <= 1'b1;
                end
                EMIT: begin
                    if (block_ready) begin
                        block_valid <= 1'b0;
                        block_last  <= 1'b0;
                        widx        <= 4'd0;
                        if (block_last) begin
                            state  <= FILL;
                            bitlen <= 64'd0;
                            first  <= 1'b1;
                        end else begin
                            state <= ret;
                            first <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_padder.sv
// Testbench for sha256_padder: table-driven and randomized messages checked against
// a byte-level FIPS 180-4 padding model, plus hand-written timing/reset sequences.
module tb_sha256_padder;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         in_last;
    logic [1:0]   in_nbytes;
    logic         block_valid;
    logic         block_ready;
    logic [511:0] block_data;
    logic         block_first;
    logic         block_last;

    int errors = 0;
    int checks = 0;

    logic [511:0] expBlk[$];
    bit           expFirst[$];
    bit           expLast[$];
    int           gotBlocks;
    logic [31:0]  lastW15;

    typedef struct {
        int          nwords;
        logic [1:0]  nb;
        int          expBlocks;
        logic [31:0] expLen;
    } vec_t;

    vec_t vecs[$];

    sha256_padder dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_last(in_last),
        .in_nbytes(in_nbytes),
        .block_valid(block_valid),
        .block_ready(block_ready),
        .block_data(block_data),
        .block_first(block_first),
        .block_last(block_last)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [511:0] actual, input logic [511:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Reference: plain byte-stream padding, then split into 64-byte blocks.
    task automatic buildExpected(input logic [31:0] w[$], input logic [1:0] nb);
        byte unsigned m[$];
        logic [63:0]  bitl;
        logic [511:0] blk;
        int           n;
        int           nblk;
        for (int i = 0; i < w.size(); i++) begin
            n = (i == w.size() - 1 && nb != 2'd0) ? int'(nb) : 4;
            for (int j = 0; j < n; j++) m.push_back(w[i][31 - 8*j -: 8]);
        end
        bitl = 64'(m.size()) * 64'd8;
        m.push_back(8'h80);
        while (m.size() % 64 != 56) m.push_back(8'h00);
        for (int j = 7; j >= 0; j--) m.push_back(bitl[8*j +: 8]);
        nblk = m.size() / 64;
        for (int b = 0; b < nblk; b++) begin
            for (int k = 0; k < 64; k++) blk[511 - 8*k -: 8] = m[64*b + k];
            expBlk.push_back(blk);
            expFirst.push_back(b == 0);
            expLast.push_back(b == nblk - 1);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] w, input bit last, input logic [1:0] nb);
        int waitCyc = 0;
        in_valid  = 1'b1;
        in_data   = w;
        in_last   = last;
        in_nbytes = nb;
        while (!in_ready && waitCyc < 400) begin
            @(posedge clk); #1;
            waitCyc++;
        end
        if (!in_ready) begin
            checkOutput("in_ready_timeout", 1, 0);
        end else begin
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = $urandom;
        in_nbytes = 2'(($urandom));
    endtask

    task automatic sendMessage(input logic [31:0] w[$], input logic [1:0] nb, input bit gaps);
        for (int i = 0; i < w.size(); i++) begin
            if (gaps) repeat ($urandom_range(2)) begin @(posedge clk); #1; end
            if (i == w.size() - 1) applyStimulus(w[i], 1'b1, nb);
            else applyStimulus(w[i], 1'b0, 2'($urandom));
        end
    endtask

    task automatic collectBlocks(input int pct, input int budget);
        int           cyc = 0;
        bit           holding = 0;
        logic [511:0] held;
        gotBlocks = 0;
        while (expBlk.size() > 0) begin
            if (cyc > budget) begin
                checkOutput("block_timeout", 64'(expBlk.size()), 0);
                expBlk.delete();
                expFirst.delete();
                expLast.delete();
                break;
            end
            block_ready = ($urandom_range(99) < pct);
            if (block_valid) begin
                if (holding) checkOutput("stable_data", block_data, held);
                checkOutput("in_ready_emit", in_ready, 0);
                if (block_ready) begin
                    checkOutput("block_data", block_data, expBlk.pop_front());
                    checkOutput("block_first", block_first, expFirst.pop_front());
                    checkOutput("block_last", block_last, expLast.pop_front());
                    lastW15 = block_data[31:0];
                    gotBlocks++;
                    holding = 0;
                end else begin
                    held    = block_data;
                    holding = 1;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        block_ready = 1'b0;
    endtask

    task automatic runMessage(input logic [31:0] w[$], input logic [1:0] nb, input int pct, input bit gaps);
        buildExpected(w, nb);
        fork
            sendMessage(w, nb, gaps);
            collectBlocks(pct, 3000);
        join
    endtask

    task automatic pulseReset(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_in_ready"}, in_ready, 1);
        checkOutput({tag, "_block_valid"}, block_valid, 0);
        checkOutput({tag, "_block_first"}, block_first, 1);
        checkOutput({tag, "_block_last"}, block_last, 0);
    endtask

    task automatic waitBlockValid(input string tag, output int edges);
        edges = 0;
        while (!block_valid && edges < 200) begin
            @(posedge clk); #1;
            edges++;
        end
        checkOutput({tag, "_valid_seen"}, block_valid, 1);
    endtask

    initial begin
        logic [31:0]  w[$];
        logic [511:0] snap;
        int           edges;

        rst         = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        in_last     = 1'b0;
        in_nbytes   = 2'd0;
        block_ready = 1'b0;
        pulseReset(2);
        checkResetState("reset");

        vecs = '{
            '{1,  2'd3, 1, 32'h0000_0018},
            '{14, 2'd3, 1, 32'h0000_01B8},
            '{14, 2'd0, 2, 32'h0000_01C0},
            '{16, 2'd0, 2, 32'h0000_0200},
            '{13, 2'd1, 1, 32'h0000_0188},
            '{15, 2'd2, 2, 32'h0000_01D0},
            '{16, 2'd3, 2, 32'h0000_01F8},
            '{17, 2'd1, 2, 32'h0000_0208},
            '{32, 2'd0, 3, 32'h0000_0400}
        };
        foreach (vecs[v]) begin
            w.delete();
            for (int i = 0; i < vecs[v].nwords; i++) w.push_back((v == 0) ? 32'h6162_6300 : $urandom);
            runMessage(w, vecs[v].nb, 100, 1'b0);
            checkOutput($sformatf("vec%0d_nblocks", v), 64'(gotBlocks), 64'(vecs[v].expBlocks));
            checkOutput($sformatf("vec%0d_len", v), lastW15, vecs[v].expLen);
        end

        // "abc" latency: valid must appear exactly 14 edges after the accepting edge.
        applyStimulus(32'h6162_6300, 1'b1, 2'd3);
        waitBlockValid("abc", edges);
        checkOutput("abc_latency", 64'(edges), 64'd14);
        checkOutput("abc_word0", block_data[511:480], 32'h6162_6380);
        checkOutput("abc_words1_14", block_data[479:32], '0);
        checkOutput("abc_word15", block_data[31:0], 32'h0000_0018);
        checkOutput("abc_first", block_first, 1);
        checkOutput("abc_last", block_last, 1);
        block_ready = 1'b1;
        @(posedge clk); #1;
        block_ready = 1'b0;
        checkOutput("abc_valid_drop", block_valid, 0);
        checkOutput("abc_in_ready_back", in_ready, 1);

        // Backpressure hold, then an immediate second message.
        applyStimulus(32'h6162_6300, 1'b1, 2'd3);
        waitBlockValid("bp", edges);
        snap = block_data;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            checkOutput("bp_valid_held", block_valid, 1);
            checkOutput("bp_data_held", block_data, snap);
            checkOutput("bp_in_ready", in_ready, 0);
        end
        block_ready = 1'b1;
        @(posedge clk); #1;
        block_ready = 1'b0;
        checkOutput("bp_valid_drop", block_valid, 0);
        checkOutput("bp_in_ready_back", in_ready, 1);
        w.delete();
        w.push_back(32'h6162_6300);
        runMessage(w, 2'd3, 100, 1'b0);
        checkOutput("b2b_len", lastW15, 32'h0000_0018);

        // Reset after 5 words discards the partial message.
        for (int i = 0; i < 5; i++) applyStimulus($urandom, 1'b0, 2'd0);
        pulseReset(1);
        checkResetState("midmsg");
        runMessage(w, 2'd3, 100, 1'b0);
        checkOutput("midmsg_len", lastW15, 32'h0000_0018);
        checkOutput("midmsg_nblocks", 64'(gotBlocks), 64'd1);

        // Reset while a block is pending.
        for (int i = 0; i < 16; i++) applyStimulus($urandom, 1'b0, 2'd0);
        waitBlockValid("emit", edges);
        pulseReset(1);
        checkResetState("emit");
        runMessage(w, 2'd3, 100, 1'b0);
        checkOutput("emit_len", lastW15, 32'h0000_0018);

        for (int r = 0; r < 25; r++) begin
            w.delete();
            repeat ($urandom_range(1, 40)) w.push_back($urandom);
            runMessage(w, 2'($urandom), $urandom_range(30, 100), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
